// File: rtl/main_memory_arbiter_pkg.sv
// Shared types for the main-memory arbiter: FSM state encoding, grant encoding and
// the grant-selection policy used when a transfer can start.
package main_memory_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

  // With both caches pending, fair mode hands the port to I-cache only if D-cache had it last.
  function automatic grant_e pick_grant(input logic i_req, input logic d_req,
                                        input logic fair, input grant_e last_grant);
    grant_e g;
    if (i_req && d_req) g = (fair && last_grant == GNT_D) ? GNT_I : GNT_D;
    else if (d_req)     g = GNT_D;
    else                g = GNT_I;
    return g;
  endfunction

endpackage

// File: rtl/main_memory_arbiter.sv
// Shares the main-memory port between I-cache refills and D-cache refills/write-backs,
// serialising block transfers and returning per-requester stall signals.
//
// state     | meaning
// ST_IDLE   | no transfer in flight; sample requests and grant one
// ST_ACCESS | memory strobe, address and data held until memory completes
// ST_RESP   | one-cycle release of the granted requester's BUSYWAIT
module main_memory_arbiter
  import main_memory_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = 28,
  parameter int BLOCK_WIDTH = 128,
  parameter bit FAIR        = 1'b1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   I_READ,
  input  logic [ADDR_WIDTH-1:0]  I_ADDRESS,
  output logic [BLOCK_WIDTH-1:0] I_READDATA,
  output logic                   I_BUSYWAIT,
  input  logic                   D_READ,
  input  logic                   D_WRITE,
  input  logic [ADDR_WIDTH-1:0]  D_ADDRESS,
  input  logic [BLOCK_WIDTH-1:0] D_WRITEDATA,
  output logic [BLOCK_WIDTH-1:0] D_READDATA,
  output logic                   D_BUSYWAIT,
  output logic                   MEM_READ,
  output logic                   MEM_WRITE,
  output logic [ADDR_WIDTH-1:0]  MEM_ADDRESS,
  output logic [BLOCK_WIDTH-1:0] MEM_WRITEDATA,
  input  logic [BLOCK_WIDTH-1:0] MEM_READDATA,
  input  logic                   MEM_BUSYWAIT
);

  arb_state_e             state_q, state_d;
  grant_e                 grant_q, grant_d;
  grant_e                 last_grant_q, last_grant_d;
  logic                   issued_q, issued_d;
  logic                   mem_read_q, mem_read_d;
  logic                   mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [BLOCK_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [BLOCK_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [BLOCK_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                   i_req, d_req, mem_done;

  assign i_req = I_READ;
  assign d_req = D_READ | D_WRITE;
  // issued masks the first ACCESS cycle, before memory has had a chance to raise its busy flag
  assign mem_done = issued_q & ~MEM_BUSYWAIT;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    issued_d     = issued_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        if (i_req || d_req) begin
          grant_d  = pick_grant(i_req, d_req, FAIR, last_grant_q);
          issued_d = 1'b0;
          state_d  = ST_ACCESS;
          if (grant_d == GNT_D) begin
            mem_addr_d  = D_ADDRESS;
            mem_wdata_d = D_WRITEDATA;
            mem_read_d  = D_READ;
            mem_write_d = D_WRITE;
          end else begin
            mem_addr_d = I_ADDRESS;
            mem_read_d = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        issued_d = 1'b1;
        if (mem_done) begin
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
          last_grant_d = grant_q;
          state_d      = ST_RESP;
          // a requester that withdrew mid-transfer does not get its block overwritten
          if (mem_read_q && grant_q == GNT_I && I_READ) i_rdata_d = MEM_READDATA;
          if (mem_read_q && grant_q == GNT_D && D_READ) d_rdata_d = MEM_READDATA;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      grant_q      <= GNT_I;
      last_grant_q <= GNT_I;
      issued_q     <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      issued_q     <= issued_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = mem_addr_q;
  assign MEM_WRITEDATA = mem_wdata_q;
  assign I_READDATA    = i_rdata_q;
  assign D_READDATA    = d_rdata_q;

  assign I_BUSYWAIT = !RESET && i_req && !(state_q == ST_RESP && grant_q == GNT_I);
  assign D_BUSYWAIT = !RESET && d_req && !(state_q == ST_RESP && grant_q == GNT_D);

endmodule

// File: tb/tb_main_memory_arbiter.sv
// Bench for main_memory_arbiter: a fair and a D-priority instance share the cache-side
// stimulus, each with its own memory model, checked every cycle against a transaction model.
module tb_main_memory_arbiter;
  localparam int AW      = 28;
  localparam int BW      = 128;
  localparam int MEM_LAT = 3;
  localparam logic [BW-1:0] W1  = 128'hDEADBEEF_CAFEF00D_12345678_00000001;
  localparam logic [BW-1:0] W2  = 128'h0BADC0DE_FEEDFACE_87654321_00000002;
  localparam logic [BW-1:0] WA5 = {16{8'hA5}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, i_read, d_read, d_write;
  logic [AW-1:0] i_addr, d_addr;
  logic [BW-1:0] d_wdata;

  logic [1:0]    i_bw, d_bw, mem_read, mem_write;
  logic [1:0]    mem_busy = '0;
  logic [1:0]    mem_done = '0;
  int            mem_cnt [2];
  logic [BW-1:0] i_rdata [2];
  logic [BW-1:0] d_rdata [2];
  logic [BW-1:0] mem_wdata [2];
  logic [BW-1:0] mem_rdata [2] = '{default: '0};
  logic [AW-1:0] mem_addr [2];
  logic [BW-1:0] store [2][16];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    main_memory_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .FAIR(g == 0)) u_dut (
      .CLK(clk), .RESET(rst),
      .I_READ(i_read), .I_ADDRESS(i_addr), .I_READDATA(i_rdata[g]), .I_BUSYWAIT(i_bw[g]),
      .D_READ(d_read), .D_WRITE(d_write), .D_ADDRESS(d_addr), .D_WRITEDATA(d_wdata),
      .D_READDATA(d_rdata[g]), .D_BUSYWAIT(d_bw[g]),
      .MEM_READ(mem_read[g]), .MEM_WRITE(mem_write[g]), .MEM_ADDRESS(mem_addr[g]),
      .MEM_WRITEDATA(mem_wdata[g]), .MEM_READDATA(mem_rdata[g]), .MEM_BUSYWAIT(mem_busy[g])
    );
  end

  function automatic logic [BW-1:0] init_word(input int j);
    if (j == 1) return W1;
    if (j == 2) return W2;
    return {96'h0, 32'h5EED_0000 | 32'(j)};
  endfunction

  // Memory: notices a strobe one edge late, stays busy MEM_LAT cycles, then completes.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mem_busy[k] <= 1'b0;
        mem_done[k] <= 1'b0;
        mem_cnt[k]  <= 0;
        for (int j = 0; j < 16; j++) store[k][j] <= init_word(j);
      end else if (!(mem_read[k] || mem_write[k])) begin
        mem_busy[k] <= 1'b0;
        mem_done[k] <= 1'b0;
      end else if (mem_done[k]) begin
        mem_busy[k] <= 1'b0;
      end else if (!mem_busy[k]) begin
        mem_busy[k] <= 1'b1;
        mem_cnt[k]  <= MEM_LAT;
      end else if (mem_cnt[k] == 1) begin
        mem_busy[k] <= 1'b0;
        mem_done[k] <= 1'b1;
        if (mem_write[k]) store[k][mem_addr[k][7:4]] <= mem_wdata[k];
        else              mem_rdata[k] <= store[k][mem_addr[k][7:4]];
      end else begin
        mem_cnt[k] <= mem_cnt[k] - 1;
      end
    end
  end

  // Transaction model: a grant occupies the port for MEM_LAT+2 cycles, then one response cycle.
  bit [1:0]      m_act = '0, m_resp = '0, m_isd = '0, m_wr = '0, m_lastd = '0;
  bit            m_valid = 1'b0;
  int            m_left [2];
  logic [AW-1:0] m_addr [2];
  logic [BW-1:0] m_wdata [2];
  logic [BW-1:0] m_idata [2];
  logic [BW-1:0] m_ddata [2];
  logic [BW-1:0] mirror [2][16];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_act[k] = 0; m_resp[k] = 0; m_isd[k] = 0; m_wr[k] = 0; m_lastd[k] = 0;
        m_addr[k] = '0; m_wdata[k] = '0; m_idata[k] = '0; m_ddata[k] = '0;
        for (int j = 0; j < 16; j++) mirror[k][j] = init_word(j);
      end else if (m_resp[k]) begin
        m_resp[k] = 0;
      end else if (m_act[k]) begin
        m_left[k] = m_left[k] - 1;
        if (m_left[k] == 0) begin
          m_act[k] = 0; m_resp[k] = 1; m_lastd[k] = m_isd[k];
          if (m_wr[k])                  mirror[k][m_addr[k][7:4]] = m_wdata[k];
          else if (m_isd[k] && d_read)  m_ddata[k] = mirror[k][m_addr[k][7:4]];
          else if (!m_isd[k] && i_read) m_idata[k] = mirror[k][m_addr[k][7:4]];
        end
      end else if (i_read || d_read || d_write) begin
        m_isd[k]  = (d_read || d_write) && !(i_read && k == 0 && m_lastd[k]);
        m_wr[k]   = m_isd[k] && d_write;
        m_act[k]  = 1;
        m_left[k] = MEM_LAT + 2;
        m_addr[k] = m_isd[k] ? d_addr : i_addr;
        if (m_isd[k]) m_wdata[k] = d_wdata;
      end
    end
    if (rst) m_valid = 1'b1;
  end

  int n_checks = 0;
  int n_fail = 0;
  logic [1:0] s_ibw, s_dbw;
  logic [1:0] prev_stb = '0;
  logic [AW:0] glog0[$];
  logic [AW:0] glog1[$];

  task automatic chk(input string nm, input int k, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, k, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic compare_all();
    logic e_ibw, e_dbw;
    for (int k = 0; k < 2; k++) begin
      s_ibw[k] = i_bw[k];
      s_dbw[k] = d_bw[k];
      if ((mem_read[k] || mem_write[k]) && !prev_stb[k]) begin
        if (k == 0) glog0.push_back({mem_write[k], mem_addr[k]});
        else        glog1.push_back({mem_write[k], mem_addr[k]});
      end
      prev_stb[k] = mem_read[k] || mem_write[k];
      if (m_valid) begin
        e_ibw = !rst && i_read && !(m_resp[k] && !m_isd[k]);
        e_dbw = !rst && (d_read || d_write) && !(m_resp[k] && m_isd[k]);
        chk("i_busywait", k, BW'(i_bw[k]), BW'(e_ibw));
        chk("d_busywait", k, BW'(d_bw[k]), BW'(e_dbw));
        chk("mem_read", k, BW'(mem_read[k]), BW'(m_act[k] && !m_wr[k]));
        chk("mem_write", k, BW'(mem_write[k]), BW'(m_act[k] && m_wr[k]));
        chk("mem_address", k, BW'(mem_addr[k]), BW'(m_addr[k]));
        chk("mem_writedata", k, mem_wdata[k], m_wdata[k]);
        chk("i_readdata", k, i_rdata[k], m_idata[k]);
        chk("d_readdata", k, d_rdata[k], m_ddata[k]);
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, i_done, d_done, d_seen;
    int exp0 [4] = '{'h20, 'h10, 'h20, 'h10};

    rst = 1; i_read = 0; d_read = 0; d_write = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) cyc();
    rst = 0;
    repeat (2) cyc();
    for (int k = 0; k < 2; k++) begin
      chk("reset_i_readdata", k, i_rdata[k], '0);
      chk("reset_mem_read", k, BW'(mem_read[k]), '0);
    end

    // single uncontended I-cache refill
    i_read = 1; i_addr = 28'h10; lat = -1; d_seen = 0;
    for (int c = 0; c < 20 && lat < 0; c++) begin
      cyc();
      if (s_dbw[0]) d_seen = 1;
      if (!s_ibw[0]) lat = c;
    end
    i_read = 0;
    chki("i_read_latency", lat, 6);
    chk("i_read_data", 0, i_rdata[0], W1);
    chki("d_busywait_quiet", d_seen, 0);
    repeat (3) cyc();

    // simultaneous requests: D first, then I
    i_read = 1; i_addr = 28'h10; d_read = 1; d_addr = 28'h20; i_done = -1; d_done = -1;
    for (int c = 0; c < 40 && (i_read || d_read); c++) begin
      cyc();
      if (d_read && !s_dbw[0]) begin d_read = 0; d_done = c; end
      if (i_read && !s_ibw[0]) begin i_read = 0; i_done = c; end
    end
    i_read = 0; d_read = 0;
    chki("contend_d_done", d_done, 6);
    chki("contend_i_done", i_done, 13);
    chk("contend_d_data", 0, d_rdata[0], W2);
    chk("contend_i_data", 0, i_rdata[0], W1);
    chk("contend_d_data", 1, d_rdata[1], W2);
    repeat (3) cyc();

    // both pending continuously
    glog0.delete(); glog1.delete();
    i_read = 1; i_addr = 28'h10; d_read = 1; d_addr = 28'h20;
    repeat (30) cyc();
    i_read = 0; d_read = 0;
    repeat (10) cyc();
    chki("fair_grant_count_ok", int'(glog0.size() >= 4), 1);
    chki("prio_grant_count_ok", int'(glog1.size() >= 4), 1);
    for (int j = 0; j < 4; j++) begin
      chki("fair_grant_seq", j < glog0.size() ? int'(glog0[j]) : -1, exp0[j]);
      chki("prio_grant_seq", j < glog1.size() ? int'(glog1[j]) : -1, 'h20);
    end

    // write-back then refill of the same block
    glog0.delete(); glog1.delete();
    d_write = 1; d_addr = 28'h30; d_wdata = WA5;
    cyc();
    i_read = 1; i_addr = 28'h30;
    for (int c = 0; c < 40 && (i_read || d_write); c++) begin
      cyc();
      if (d_write && !s_dbw[0]) d_write = 0;
      if (i_read && !s_ibw[0]) i_read = 0;
    end
    i_read = 0; d_write = 0;
    repeat (2) cyc();
    chki("wb_first_is_write", glog0.size() >= 1 ? int'(glog0[0]) : -1, int'({1'b1, 28'h30}));
    chki("wb_then_read", glog0.size() >= 2 ? int'(glog0[1]) : -1, int'({1'b0, 28'h30}));
    chk("wb_read_data", 0, i_rdata[0], WA5);
    chk("wb_read_data", 1, i_rdata[1], WA5);

    // I withdraws mid-transfer
    glog0.delete();
    i_read = 1; i_addr = 28'h40;
    repeat (3) cyc();
    i_read = 0;
    repeat (8) cyc();
    chki("drop_read_issued", glog0.size() == 1 ? int'(glog0[0]) : -1, 'h40);
    chk("drop_data_kept", 0, i_rdata[0], WA5);
    d_read = 1; d_addr = 28'h20; lat = -1;
    for (int c = 0; c < 20 && lat < 0; c++) begin
      cyc();
      if (!s_dbw[0]) lat = c;
    end
    d_read = 0;
    chki("after_drop_d_latency", lat, 6);
    repeat (3) cyc();

    // reset in the middle of an access
    i_read = 1; i_addr = 28'h10;
    repeat (3) cyc();
    rst = 1;
    cyc();
    chki("reset_busywait_low", int'(s_ibw), 0);
    cyc();
    chki("reset_busywait_low", int'(s_ibw), 0);
    for (int k = 0; k < 2; k++) begin
      chk("midreset_mem_read", k, BW'(mem_read[k]), '0);
      chk("midreset_i_readdata", k, i_rdata[k], '0);
      chk("midreset_d_readdata", k, d_rdata[k], '0);
    end
    rst = 0; i_read = 0;
    repeat (2) cyc();
    i_read = 1; i_addr = 28'h10; lat = -1;
    for (int c = 0; c < 20 && lat < 0; c++) begin
      cyc();
      if (!s_ibw[0]) lat = c;
    end
    i_read = 0;
    chki("post_reset_latency", lat, 6);
    chk("post_reset_data", 0, i_rdata[0], W1);
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
